wb_flush_ctrl: RTL
==================

Name: wb_flush_ctrl

Overview:
- Central redirect/flush controller beside the WB stage.
- Arbitrates the three WB redirect sources (exception, ertn, TLB-op refetch) and issues one flush pulse with a resolved target PC to IF/ID/EXE/MEM.
- Tracks the post-flush squash window, so wrong-path instructions still draining into WB never write the regfile, CSRs or TLB.
- Replaces the ad-hoc flush_reg logic in WB; WB consumes wb_squash.

Parameters:
- SQUASH_MIN, 2, minimum cycles wb_squash stays high after a flush, regardless of MEM->WB traffic.
- PC_W, 32, PC / target width.

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous, active-low reset
- wb_valid  in  1  WB holds a valid instruction
- wb_ex  in  1  WB instruction raises an exception (already gated by wb_valid)
- wb_ecode  in  6  ecode of that exception
- ertn_flush  in  1  WB instruction is ertn (gated by wb_valid)
- refetch  in  1  WB instruction is tlbwr/tlbfill/tlbrd/csr-write needing refetch (gated by wb_valid)
- wb_pc  in  32  PC of the WB instruction
- csr_eentry  in  32  general exception entry
- csr_tlbrentry  in  32  TLB-refill entry
- csr_era  in  32  return address
- mem_to_wb_valid  in  1  MEM offers an instruction
- wb_allow_in  in  1  WB accepts this cycle
- flush  out  1  one-cycle redirect pulse
- flush_target  out  32  redirect PC, valid when flush=1
- flush_kind  out  2  0 none, 1 exception, 2 ertn, 3 refetch
- wb_squash  out  1  WB must suppress rf/csr/tlb writes and events
- flush_cnt  out  16  saturating count of issued flushes (debug)

Behaviour:
- Reset (resetn low, async): state IDLE, squash counter 0, flush_cnt 0, registered target 0. All outputs 0 while reset is asserted.
- FSM states:
  - IDLE: no flush outstanding.
  - SQUASH: flush issued; waiting for the window to close.
- Event: evt = wb_valid & ~wb_squash & (wb_ex | ertn_flush | refetch).
- Priority: wb_ex > ertn_flush > refetch. A lower source is ignored when a higher one is set in the same cycle.
- Target:
  - exception with wb_ecode == 6'h3F: csr_tlbrentry
  - other exception: csr_eentry
  - ertn: csr_era
  - refetch: wb_pc + 4 (mod 2^32, wraps 0xFFFFFFFC -> 0x0)
- IDLE & evt:
  - flush = 1 combinationally in the same cycle.
  - flush_kind and flush_target are driven combinationally and also captured into registers.
  - Next state SQUASH; counter loaded with SQUASH_MIN-1; flush_cnt++, saturating at 0xFFFF.
- SQUASH:
  - wb_squash = 1; flush = 0. Any wb_ex/ertn/refetch input is ignored (wrong path).
  - Counter decrements to 0 and holds there.
  - Exit to IDLE at the cycle end when counter == 0 AND mem_to_wb_valid & wb_allow_in. This means the first instruction fetched after the redirect enters WB unsquashed.
- flush_kind and flush_target hold their registered values during SQUASH. Both read 0 in IDLE when there is no event.
- wb_squash is also asserted combinationally in the event cycle itself, so the faulting or ertn instruction's regfile write is suppressed.
  - Exception: refetch-type instructions still commit. WB gates on flush_kind==3 separately to allow their write.
- No handshake back-pressure: flush is never stalled.
- Reset mid-SQUASH returns to IDLE immediately.

Decomposition:
- Shared package (cpu_defs):
  - ecode constants, including ECODE_TLBR = 6'h3F
  - flush_kind encodings FK_NONE/FK_EXC/FK_ERTN/FK_REFETCH
  - state encodings
- One sub-module: flush_target_mux (combinational priority select + pc+4 adder), kept separate for unit test.
- FSM, counter and flush_cnt live in the top.

Test Plan:
1. Exception: wb_valid=1, wb_ex=1, ecode=0x0B, eentry=0x1C008000 -> flush=1, target=0x1C008000, kind=1 that cycle. wb_squash stays 1 for >=2 cycles and until the next MEM->WB accept.
2. TLB refill: ecode=0x3F, tlbrentry=0x1C00F000 -> target=0x1C00F000, kind=1.
3. Simultaneous sources: wb_ex=1, ertn=1, refetch=1 -> kind=1, eentry chosen, flush_cnt +1 only.
4. Refetch: wb_pc=0x1C000100 -> target=0x1C000104, kind=3. With wb_pc=0xFFFFFFFC -> target=0x00000000.
5. Squash window: issue ertn (era=0x1C000200), then raise wb_ex 1 cycle later -> no second flush. With SQUASH_MIN=2 and a MEM->WB accept on cycle+1, exit occurs no earlier than cycle+2.
6. Reset: drop resetn asynchronously mid-SQUASH -> wb_squash/flush/flush_cnt read 0 before the next clk edge; after release, a new event flushes normally.

Source files
------------

// File: rtl/wb_flush_ctrl_pkg.sv
// cpu_defs: shared encodings for the WB redirect/flush controller.
//   - exception codes (ECODE_TLBR selects the TLB-refill entry)
//   - flush_kind encodings reported on flush_kind
//   - controller FSM state encodings
package cpu_defs;

  localparam logic [5:0] ECODE_INT  = 6'h00;
  localparam logic [5:0] ECODE_PIL  = 6'h01;
  localparam logic [5:0] ECODE_PIS  = 6'h02;
  localparam logic [5:0] ECODE_PIF  = 6'h03;
  localparam logic [5:0] ECODE_PME  = 6'h04;
  localparam logic [5:0] ECODE_ADE  = 6'h08;
  localparam logic [5:0] ECODE_ALE  = 6'h09;
  localparam logic [5:0] ECODE_SYS  = 6'h0B;
  localparam logic [5:0] ECODE_BRK  = 6'h0C;
  localparam logic [5:0] ECODE_INE  = 6'h0D;
  localparam logic [5:0] ECODE_TLBR = 6'h3F;

  typedef enum logic [1:0] {
    FK_NONE    = 2'd0,
    FK_EXC     = 2'd1,
    FK_ERTN    = 2'd2,
    FK_REFETCH = 2'd3
  } flush_kind_e;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_SQUASH = 1'b1
  } flush_state_e;

endpackage

// File: rtl/wb_flush_ctrl_target_mux.sv
// flush_target_mux: priority select of the WB redirect source and its target.
//   wb_ex > ertn_flush > refetch; lower sources are ignored when a higher
//   one is set.
// Ports:
//   wb_ex, ertn_flush, refetch  redirect requests (already valid-gated)
//   wb_ecode                    exception code (TLBR picks csr_tlbrentry)
//   wb_pc                       PC of the WB instruction (refetch -> pc+4)
//   csr_eentry/tlbrentry/era    candidate targets
//   any                         some source is requesting
//   kind / target               selected kind and redirect PC
module flush_target_mux
  import cpu_defs::*;
#(
  parameter int PC_W = 32
) (
  input  logic            wb_ex,
  input  logic            ertn_flush,
  input  logic            refetch,
  input  logic [5:0]      wb_ecode,
  input  logic [PC_W-1:0] wb_pc,
  input  logic [PC_W-1:0] csr_eentry,
  input  logic [PC_W-1:0] csr_tlbrentry,
  input  logic [PC_W-1:0] csr_era,
  output logic            any,
  output flush_kind_e     kind,
  output logic [PC_W-1:0] target
);

  logic [PC_W-1:0] pc_next;

  // Wraps naturally at the top of the address space.
  assign pc_next = wb_pc + PC_W'(4);
  assign any     = wb_ex | ertn_flush | refetch;

  always_comb begin
    kind   = FK_NONE;
    target = '0;
    if (wb_ex) begin
      kind   = FK_EXC;
      target = (wb_ecode == ECODE_TLBR) ? csr_tlbrentry : csr_eentry;
    end else if (ertn_flush) begin
      kind   = FK_ERTN;
      target = csr_era;
    end else if (refetch) begin
      kind   = FK_REFETCH;
      target = pc_next;
    end
  end

endmodule

// File: rtl/wb_flush_ctrl.sv
// wb_flush_ctrl: central redirect/flush controller beside WB.
//   Issues a one-cycle flush with a resolved target when WB raises an
//   exception, ertn or refetch, then holds wb_squash until at least
//   SQUASH_MIN cycles have passed and the first post-redirect instruction
//   is accepted from MEM into WB.
// Ports:
//   clk, resetn                      clock, async active-low reset
//   wb_valid, wb_ex, wb_ecode        WB instruction and its exception
//   ertn_flush, refetch              other redirect requests
//   wb_pc, csr_eentry/tlbrentry/era  PC sources for the target
//   mem_to_wb_valid, wb_allow_in     MEM->WB handshake (closes the window)
//   flush, flush_target, flush_kind  redirect pulse and its description
//   wb_squash                        suppress WB side effects
//   flush_cnt                        saturating count of flushes
module wb_flush_ctrl
  import cpu_defs::*;
#(
  parameter int SQUASH_MIN = 2,
  parameter int PC_W       = 32
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            wb_valid,
  input  logic            wb_ex,
  input  logic [5:0]      wb_ecode,
  input  logic            ertn_flush,
  input  logic            refetch,
  input  logic [PC_W-1:0] wb_pc,
  input  logic [PC_W-1:0] csr_eentry,
  input  logic [PC_W-1:0] csr_tlbrentry,
  input  logic [PC_W-1:0] csr_era,
  input  logic            mem_to_wb_valid,
  input  logic            wb_allow_in,
  output logic            flush,
  output logic [PC_W-1:0] flush_target,
  output logic [1:0]      flush_kind,
  output logic            wb_squash,
  output logic [15:0]     flush_cnt
);

  localparam int CNT_W = (SQUASH_MIN > 1) ? $clog2(SQUASH_MIN) : 1;

  flush_state_e    state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  flush_kind_e     kind_q;
  logic [PC_W-1:0] target_q;

  logic            mux_any;
  flush_kind_e     mux_kind;
  logic [PC_W-1:0] mux_target;
  logic            evt;

  flush_target_mux #(.PC_W(PC_W)) u_mux (
    .wb_ex         (wb_ex),
    .ertn_flush    (ertn_flush),
    .refetch       (refetch),
    .wb_ecode      (wb_ecode),
    .wb_pc         (wb_pc),
    .csr_eentry    (csr_eentry),
    .csr_tlbrentry (csr_tlbrentry),
    .csr_era       (csr_era),
    .any           (mux_any),
    .kind          (mux_kind),
    .target        (mux_target)
  );

  // Squash is only ever outstanding in ST_SQUASH, so the IDLE state stands
  // in for ~wb_squash and breaks the loop through the output. resetn is
  // folded in so the combinational path stays quiet during reset.
  assign evt = resetn & wb_valid & (state == ST_IDLE) & mux_any;

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    flush        = 1'b0;
    wb_squash    = 1'b0;
    flush_kind   = FK_NONE;
    flush_target = '0;
    case (state)
      ST_IDLE: begin
        if (evt) begin
          flush        = 1'b1;
          wb_squash    = 1'b1;
          flush_kind   = mux_kind;
          flush_target = mux_target;
          state_nxt    = ST_SQUASH;
          cnt_nxt      = CNT_W'(SQUASH_MIN - 1);
        end
      end
      ST_SQUASH: begin
        wb_squash    = 1'b1;
        flush_kind   = kind_q;
        flush_target = target_q;
        // Count down first; only once the minimum window has elapsed does
        // a MEM->WB accept (the redirected instruction) close it.
        if (cnt != '0)
          cnt_nxt = cnt - CNT_W'(1);
        else if (mem_to_wb_valid && wb_allow_in)
          state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      kind_q    <= FK_NONE;
      target_q  <= '0;
      flush_cnt <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (flush) begin
        kind_q   <= mux_kind;
        target_q <= mux_target;
        if (flush_cnt != 16'hFFFF) flush_cnt <= flush_cnt + 16'd1;
      end
    end
  end

endmodule
